lives_controller: RTL
=====================

LIVES_CONTROLLER -- requirements
Module: lives_controller

Interface
REQ-001 SHALL have parameter INVULN_CYCLES, default 100, invulnerability length in clock cycles (legal range 1..65535).
REQ-002 SHALL have parameter MAX_LIVES, default 9, saturation ceiling for lives (legal range 1..15).
REQ-003 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port clr_n  in  1  synchronous active-low reset.
REQ-005 SHALL have port start  in  1  level; begins or restarts a game.
REQ-006 SHALL have port collision  in  1  single-cycle pulse; ship hit by asteroid.
REQ-007 SHALL have port extra_life  in  1  single-cycle pulse; bonus-life award.
REQ-008 SHALL have port lives_q  in  4  current value of the external lives decrementer.
REQ-009 SHALL have port lives_clr  out  1  decrementer clear; sets lives to 3.
REQ-010 SHALL have port lives_ld  out  1  decrementer parallel load.
REQ-011 SHALL have port lives_d  out  4  decrementer load data.
REQ-012 SHALL have port lives_en  out  1  decrementer count enable; drives both ent and enp.
REQ-013 SHALL have port invulnerable  out  1  high in state INVULN.
REQ-014 SHALL have port game_over  out  1  high in state GAME_OVER.
REQ-015 SHALL have port state  out  3  encoded FSM state: IDLE=0, PLAYING=1, HIT=2, INVULN=3, GAME_OVER=4.

Function
REQ-016 SHALL implement FSM states IDLE, PLAYING, HIT, INVULN, GAME_OVER; codes 5..7 unreachable and SHALL return to IDLE on the next edge.
REQ-017 IDLE: lives_clr=1; start -> PLAYING; collision and extra_life ignored.
REQ-018 PLAYING: collision -> HIT; otherwise remain.
REQ-019 HIT: lasts exactly one cycle with lives_en=1; if the lives_q value sampled in HIT is <=1 -> GAME_OVER, else -> INVULN.
REQ-020 HIT -> INVULN SHALL load the 16-bit timer with INVULN_CYCLES-1; in INVULN the timer decrements each cycle; at timer==0 -> PLAYING, so INVULN lasts exactly INVULN_CYCLES cycles.
REQ-021 INVULN: collision ignored (no decrement, no state change).
REQ-022 GAME_OVER: game_over=1, lives_en=0; start -> PLAYING with lives_clr=1 in that same cycle (Mealy), so lives_q is 3 on entry to PLAYING.
REQ-023 lives_en SHALL be 1 only in HIT; lives_clr SHALL be 1 only in IDLE or in GAME_OVER with start=1.
REQ-024 lives_ld and lives_clr SHALL never be asserted in the same cycle; lives_ld and lives_en SHALL never be asserted in the same cycle.
REQ-025 Collision arriving in the same cycle as the PLAYING->HIT transition edge from a prior collision produces only one decrement; pulses during HIT are dropped.
REQ-026 Outputs other than lives_ld, lives_d and the REQ-022 lives_clr term SHALL be pure decodes of state.

Reset
REQ-027 clr_n=0 at a rising edge SHALL force state=IDLE and timer=0, regardless of current state, including mid-INVULN and mid-HIT.
REQ-028 After the reset edge: lives_clr=1, lives_ld=0, lives_d=0, lives_en=0, invulnerable=0, game_over=0, state=0.
REQ-029 clr_n SHALL take priority over start, collision and extra_life.

Configuration
REQ-030 Macro LIVES_EXTRA_LIFE_EN SHALL gate the bonus-life feature.
REQ-031 With LIVES_EXTRA_LIFE_EN defined: in PLAYING or INVULN, extra_life=1 with lives_q<MAX_LIVES SHALL assert lives_ld=1 and lives_d=lives_q+1 in that cycle; at lives_q>=MAX_LIVES it is ignored; in IDLE, HIT, GAME_OVER it is ignored.
REQ-032 With LIVES_EXTRA_LIFE_EN defined, simultaneous extra_life and collision in PLAYING SHALL load lives_q+1 then decrement in HIT (net unchanged).
REQ-033 Without LIVES_EXTRA_LIFE_EN: extra_life port present but ignored; lives_ld=0 and lives_d=0 constantly.

Verification (INVULN_CYCLES=4, MAX_LIVES=9, decrementer attached)
REQ-034 Reset, start pulse -> lives_q=3, state=PLAYING; collision pulse -> one HIT cycle with lives_en=1, lives_q=2, invulnerable=1 for exactly 4 cycles, then PLAYING.
REQ-035 Collision pulses every cycle throughout INVULN -> lives_q stays 2, no HIT entry.
REQ-036 Three separated collisions from lives_q=3 -> third HIT samples lives_q=1, lives_q=0, game_over=1; start -> lives_q=3, state=PLAYING, game_over=0.
REQ-037 Defined macro: extra_life at lives_q=9 -> lives_q stays 9; at lives_q=2 -> lives_q=3; simultaneous with collision at lives_q=2 -> lives_q=2, state HIT then INVULN.
REQ-038 clr_n=0 for one cycle during INVULN with timer=2 -> next cycle state=IDLE, invulnerable=0, lives_clr=1, lives_q=3.

Source files
------------

// File: rtl/lives_controller.sv
// rtl/lives_controller.sv - lives/invulnerability FSM driving an external lives decrementer (optional bonus life: LIVES_EXTRA_LIFE_EN)
module lives_controller #(
    parameter int unsigned INVULN_CYCLES = 100,
    parameter int unsigned MAX_LIVES     = 9
) (
    input  logic       clock,
    input  logic       clr_n,
    input  logic       start,
    input  logic       collision,
    input  logic       extra_life,
    input  logic [3:0] lives_q,
    output logic       lives_clr,
    output logic       lives_ld,
    output logic [3:0] lives_d,
    output logic       lives_en,
    output logic       invulnerable,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAYING   = 3'd1,
        S_HIT       = 3'd2,
        S_INVULN    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam logic [15:0] TIMER_LOAD = 16'(INVULN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;

    // Next-state and invulnerability timer; HIT always lasts one cycle, INVULN lasts INVULN_CYCLES
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_PLAYING;
            end
            S_PLAYING: begin
                if (collision) state_d = S_HIT;
            end
            S_HIT: begin
                // lives_q still holds the pre-decrement value here
                if (lives_q <= 4'd1) begin
                    state_d = S_GAME_OVER;
                end else begin
                    state_d = S_INVULN;
                    timer_d = TIMER_LOAD;
                end
            end
            S_INVULN: begin
                if (timer_q == 16'd0) state_d = S_PLAYING;
                else                  timer_d = timer_q - 16'd1;
            end
            S_GAME_OVER: begin
                if (start) state_d = S_PLAYING;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 16'd0;
            end
        endcase
    end

    // State and timer registers with synchronous clear
    always_ff @(posedge clock) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            timer_q <= 16'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Decrementer controls decoded from state; clear in GAME_OVER is Mealy on start so lives is 3 on entry to PLAYING
    always_comb begin
        state        = state_q;
        lives_en     = (state_q == S_HIT);
        invulnerable = (state_q == S_INVULN);
        game_over    = (state_q == S_GAME_OVER);
        lives_clr    = (state_q == S_IDLE) || ((state_q == S_GAME_OVER) && start);
    end

`ifdef LIVES_EXTRA_LIFE_EN
    localparam logic [3:0] MAX_L = 4'(MAX_LIVES);

    logic bonus_ok;

    // Bonus life loads lives_q+1 below the ceiling, only while the ship is alive and not being hit
    always_comb begin
        bonus_ok = ((state_q == S_PLAYING) || (state_q == S_INVULN)) &&
                   extra_life && (lives_q < MAX_L);
        lives_ld = bonus_ok;
        lives_d  = bonus_ok ? (lives_q + 4'd1) : 4'd0;
    end
`else
    logic unused_extra_life;

    // Bonus-life feature absent: load port held idle
    always_comb begin
        unused_extra_life = extra_life;
        lives_ld          = 1'b0;
        lives_d           = 4'd0;
    end
`endif

endmodule
